// File: rtl/mem_init_pkg.sv
// mem_init_pkg: shared types and defaults for the memory initiator
// Provides the FSM state type and the default address/data widths and sweep fill value.
package mem_init_pkg;
  typedef enum logic [2:0] {SWEEP, IDLE, ISSUE, CAPT, RESP} state_t;
  localparam int ADDR_W_DEFAULT = 2;
  localparam int DATA_W_DEFAULT = 8;
  localparam logic [DATA_W_DEFAULT-1:0] FILL_DEFAULT = 8'hFF;
endpackage

// File: rtl/mem_initiator.sv
// mem_initiator: drives a single-port synchronous memory from a valid/ready request channel
// Ports:
//   i_clk, i_reset (async, active-low)
//   request  : i_req_valid, o_req_ready, i_req_write, i_req_addr, i_req_wdata
//   response : o_rsp_valid, i_rsp_ready, o_rsp_write, o_rsp_rdata
//   memory   : o_mem_addr, o_mem_wr_en, o_mem_rd_en, o_mem_wdata, i_mem_rdata
//   status   : o_init_done (post-reset fill sweep finished)
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter bit INIT_SWEEP = 1'b1,
  parameter logic [DATA_W-1:0] FILL = FILL_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_write,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr_en,
  output logic              o_mem_rd_en,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_init_done
);
  // the counter reaching DEPTH means address DEPTH-1 was driven on the previous edge
  localparam logic [ADDR_W:0] CNT_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  state_t r_state, w_state;
  logic [ADDR_W:0] r_cnt, w_cnt;
  logic r_write, w_write;
  logic r_req_ready, w_req_ready;
  logic r_rsp_valid, w_rsp_valid;
  logic r_rsp_write, w_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic r_mem_wr_en, w_mem_wr_en;
  logic r_mem_rd_en, w_mem_rd_en;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic r_init_done, w_init_done;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= INIT_SWEEP ? SWEEP : IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_wr_en <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wdata <= '0;
      r_init_done <= ~INIT_SWEEP;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_write     <= w_write;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_write <= w_rsp_write;
      r_rsp_rdata <= w_rsp_rdata;
      r_mem_addr  <= w_mem_addr;
      r_mem_wr_en <= w_mem_wr_en;
      r_mem_rd_en <= w_mem_rd_en;
      r_mem_wdata <= w_mem_wdata;
      r_init_done <= w_init_done;
    end
  end

  // strobes and req_ready default low so each is a single registered pulse unless re-asserted
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_write     = r_write;
    w_req_ready = 1'b0;
    w_rsp_valid = r_rsp_valid;
    w_rsp_write = r_rsp_write;
    w_rsp_rdata = r_rsp_rdata;
    w_mem_addr  = r_mem_addr;
    w_mem_wr_en = 1'b0;
    w_mem_rd_en = 1'b0;
    w_mem_wdata = r_mem_wdata;
    w_init_done = r_init_done;
    case (r_state)
      SWEEP: begin
        if (r_cnt == CNT_END) begin
          w_init_done = 1'b1;
          w_req_ready = 1'b1;
          w_state     = IDLE;
        end else begin
          w_mem_addr  = r_cnt[ADDR_W-1:0];
          w_mem_wdata = FILL;
          w_mem_wr_en = 1'b1;
          w_cnt       = r_cnt + CNT_ONE;
        end
      end
      IDLE: begin
        if (r_req_ready && i_req_valid) begin
          w_write     = i_req_write;
          w_mem_addr  = i_req_addr;
          w_mem_wdata = i_req_wdata;
          w_mem_wr_en = i_req_write;
          w_mem_rd_en = ~i_req_write;
          w_state     = ISSUE;
        end else begin
          w_req_ready = 1'b1;
        end
      end
      ISSUE: begin
        w_rsp_valid = r_write;
        w_rsp_write = r_write ? 1'b1 : r_rsp_write;
        w_rsp_rdata = r_write ? '0 : r_rsp_rdata;
        w_state     = r_write ? RESP : CAPT;
      end
      CAPT: begin
        w_rsp_rdata = i_mem_rdata;
        w_rsp_valid = 1'b1;
        w_rsp_write = 1'b0;
        w_state     = RESP;
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_req_ready = 1'b1;
          w_state     = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_write = r_rsp_write;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wr_en = r_mem_wr_en;
  assign o_mem_rd_en = r_mem_rd_en;
  assign o_mem_wdata = r_mem_wdata;
  assign o_init_done = r_init_done;
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized self-checking bench for mem_initiator against a memory-array reference
module tb_mem_initiator;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic a_rst_n, a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_write;
  logic a_mem_wr_en, a_mem_rd_en, a_init_done;
  logic [1:0] a_req_addr, a_mem_addr;
  logic [7:0] a_req_wdata, a_rsp_rdata, a_mem_wdata, a_mem_rdata;
  logic b_rst_n, b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_write;
  logic b_mem_wr_en, b_mem_rd_en, b_init_done;
  logic [1:0] b_req_addr, b_mem_addr;
  logic [7:0] b_req_wdata, b_rsp_rdata, b_mem_wdata, b_mem_rdata;

  mem_initiator #(.ADDR_W(2), .DATA_W(8), .INIT_SWEEP(1'b1), .FILL(8'hFF)) u_dut_a (
    .i_clk(clk), .i_reset(a_rst_n),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_write(a_req_write),
    .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready), .o_rsp_write(a_rsp_write),
    .o_rsp_rdata(a_rsp_rdata),
    .o_mem_addr(a_mem_addr), .o_mem_wr_en(a_mem_wr_en), .o_mem_rd_en(a_mem_rd_en),
    .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata), .o_init_done(a_init_done));

  mem_initiator #(.ADDR_W(2), .DATA_W(8), .INIT_SWEEP(1'b0), .FILL(8'hFF)) u_dut_b (
    .i_clk(clk), .i_reset(b_rst_n),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_write(b_req_write),
    .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_write(b_rsp_write),
    .o_rsp_rdata(b_rsp_rdata),
    .o_mem_addr(b_mem_addr), .o_mem_wr_en(b_mem_wr_en), .o_mem_rd_en(b_mem_rd_en),
    .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata), .o_init_done(b_init_done));

  // memory responders: one-cycle registered read, no reset of contents
  logic [7:0] a_mem [4];
  logic [7:0] b_mem [4];
  always @(posedge clk) begin
    if (a_mem_wr_en) a_mem[a_mem_addr] <= a_mem_wdata;
    if (a_mem_rd_en) a_mem_rdata <= a_mem[a_mem_addr];
    if (b_mem_wr_en) b_mem[b_mem_addr] <= b_mem_wdata;
    if (b_mem_rd_en) b_mem_rdata <= b_mem[b_mem_addr];
  end

  int a_strobes = 0, a_both = 0, b_writes = 0, b_strobes = 0;
  always @(negedge clk) begin
    if (a_mem_wr_en || a_mem_rd_en) a_strobes++;
    if (a_mem_wr_en && a_mem_rd_en) a_both++;
    if (b_mem_wr_en) b_writes++;
    if (b_mem_wr_en || b_mem_rd_en) b_strobes++;
  end

  logic [7:0] ref_mem [4];

  // called at the negedge where reset is released; ends at the negedge after edge 5
  task automatic a_sweep_check();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sweep_wr_en", a_mem_wr_en, 1);
      check("sweep_addr", a_mem_addr, i);
      check("sweep_wdata", a_mem_wdata, 8'hFF);
      check("sweep_req_ready", a_req_ready, 0);
      check("sweep_init_done", a_init_done, 0);
    end
    @(negedge clk);
    check("sweep_end_wr_en", a_mem_wr_en, 0);
    check("sweep_init_done_hi", a_init_done, 1);
    check("sweep_req_ready_hi", a_req_ready, 1);
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
  endtask

  task automatic a_txn(input bit wr, input logic [1:0] addr, input logic [7:0] data, input int hold);
    int t, lat, s0;
    logic [7:0] exp;
    a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = data;
    t = 0;
    while (!a_req_ready && t < 10) begin @(negedge clk); t++; end
    check("accept_wait", a_req_ready, 1);
    if (!a_req_ready) begin a_req_valid = 1'b0; return; end
    s0 = a_strobes;
    @(negedge clk);
    a_req_valid = 1'b0;
    check("strobe_kind", {a_mem_wr_en, a_mem_rd_en}, wr ? 2'b10 : 2'b01);
    check("issue_addr", a_mem_addr, addr);
    check("busy_req_ready", a_req_ready, 0);
    exp = wr ? 8'h00 : ref_mem[addr];
    if (wr) ref_mem[addr] = data;
    a_rsp_ready = (hold == 0);
    lat = 0;
    while (!a_rsp_valid && lat < 8) begin @(negedge clk); lat++; end
    check("rsp_latency", lat, wr ? 1 : 2);
    check("rsp_write", a_rsp_write, wr);
    check("rsp_rdata", a_rsp_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", a_rsp_valid, 1);
      check("hold_rdata", a_rsp_rdata, exp);
      check("hold_req_ready", a_req_ready, 0);
    end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_consumed", a_rsp_valid, 0);
    check("idle_req_ready", a_req_ready, 1);
    check("strobe_count", a_strobes - s0, 1);
  endtask

  initial begin
    int t, s0;
    logic [7:0] exp_b [4];
    for (int i = 0; i < 4; i++) begin a_mem[i] = 8'($urandom); b_mem[i] = 8'($urandom); end
    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", a_req_ready, 0);
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_strobes", {a_mem_wr_en, a_mem_rd_en}, 0);
    check("rst_init_done", a_init_done, 0);
    a_rst_n = 1'b1;
    a_sweep_check();
    a_txn(1'b1, 2'd2, 8'h5A, 0);
    a_txn(1'b0, 2'd2, 8'h00, 0);
    a_txn(1'b0, 2'd3, 8'h00, 0);
    a_txn(1'b0, 2'd2, 8'h00, 3);
    for (int i = 0; i < 24; i++)
      a_txn(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), $urandom_range(0, 3));
    a_txn(1'b1, 2'd2, 8'h5A, 0);
    // abort a read while it is capturing
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 2'd2;
    t = 0;
    while (!a_req_ready && t < 10) begin @(negedge clk); t++; end
    check("abort_accept", a_req_ready, 1);
    @(negedge clk);
    a_req_valid = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b0;
    #1;
    check("abort_req_ready", a_req_ready, 0);
    check("abort_rsp_valid", a_rsp_valid, 0);
    check("abort_rsp_write", a_rsp_write, 0);
    check("abort_rsp_rdata", a_rsp_rdata, 0);
    check("abort_mem_addr", a_mem_addr, 0);
    check("abort_strobes", {a_mem_wr_en, a_mem_rd_en}, 0);
    check("abort_mem_wdata", a_mem_wdata, 0);
    check("abort_init_done", a_init_done, 0);
    repeat (2) @(negedge clk);
    check("abort_no_rsp", a_rsp_valid, 0);
    // a request held during the sweep and dropped before acceptance must not be taken
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 2'd1; a_req_wdata = 8'h33;
    a_rst_n = 1'b1;
    a_sweep_check();
    a_req_valid = 1'b0;
    s0 = a_strobes;
    repeat (2) @(negedge clk);
    check("drop_no_strobe", a_strobes - s0, 0);
    check("drop_no_rsp", a_rsp_valid, 0);
    a_txn(1'b0, 2'd2, 8'h00, 0);
    a_txn(1'b0, 2'd1, 8'h00, 0);
    check("strobe_exclusive", a_both, 0);

    // no-sweep instance: back-to-back writes with rsp_ready tied high
    check("b_rst_init_done", b_init_done, 1);
    check("b_rst_req_ready", b_req_ready, 0);
    b_rst_n = 1'b1;
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 2'd0; b_req_wdata = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!b_req_ready && t < 10) begin @(negedge clk); t++; end
      check("b_accept", b_req_ready, 1);
      if (i > 0) check("b_spacing", 2 + t, 3);
      exp_b[i] = b_req_wdata;
      @(negedge clk);
      check("b_wr_en", b_mem_wr_en, 1);
      check("b_addr", b_mem_addr, i);
      check("b_wdata", b_mem_wdata, exp_b[i]);
      if (i < 3) begin b_req_addr = 2'(i + 1); b_req_wdata = 8'($urandom); end
      else b_req_valid = 1'b0;
      @(negedge clk);
      check("b_pulse", b_mem_wr_en, 0);
      check("b_rsp_valid", b_rsp_valid, 1);
      check("b_rsp_write", b_rsp_write, 1);
      check("b_rsp_rdata", b_rsp_rdata, 0);
      check("b_init_done", b_init_done, 1);
    end
    repeat (3) @(negedge clk);
    check("b_write_count", b_writes, 4);
    check("b_strobe_count", b_strobes, 4);
    for (int i = 0; i < 4; i++) check("b_mem_content", b_mem[i], exp_b[i]);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
